sa_wt_cache: RTL and testbench
==============================

// Module: sa_wt_cache
// PURPOSE
//  Parametrised N-way set-associative, write-through, no-write-allocate data cache
//  between the core load/store port and the memory port. Word-sized lines.
//  Per-set age-based LRU replacement and a blocking miss FSM with req/ack memory handshake.
//  Successor to the single-entry direct-mapped cache; adds associativity, LRU, fill and invalidate.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width
//  DATA_WIDTH  32  word/line width
//  SETS        8   number of sets, power of 2, >=2; INDEX_W = log2(SETS)
//  WAYS        2   ways per set, power of 2 (1,2,4,8); AGE_W = max(1,log2(WAYS))
// PORTS
//  clk         in   1           clock, rising edge
//  rst_n       in   1           asynchronous active-low reset
//  read_en     in   1           load request, sampled in IDLE
//  write_en    in   1           store request, sampled in IDLE
//  addr        in   ADDR_WIDTH  byte address; addr[1:0] ignored
//  write_data  in   DATA_WIDTH  store data
//  invalidate  in   1           clear all valid bits (honoured in IDLE only)
//  read_data   out  DATA_WIDTH  load data, valid when read_en && !stall
//  hit         out  1           1-cycle pulse: lookup hit
//  miss        out  1           1-cycle pulse: lookup miss
//  stall       out  1           core must hold request and addr/data stable
//  mem_req     out  1           memory request
//  mem_we      out  1           1 = write, 0 = read
//  mem_addr    out  ADDR_WIDTH  word-aligned address ([1:0]=0)
//  mem_wdata   out  DATA_WIDTH  write data
//  mem_rdata   in   DATA_WIDTH  read data, valid with mem_ack
//  mem_ack     in   1           completes request; ignored while mem_req=0
// BEHAVIOUR
//  Address split: tag = addr[AW-1:2+INDEX_W], index = addr[2+INDEX_W-1:2].
//  Storage per way/set: valid, tag, data, age[AGE_W].
//  Reset (async): state=IDLE; all valid=0; age[w]=w in every set; all outputs 0.
//    Data/tag arrays are not reset.
//  Reset mid-transaction: mem_req drops immediately; memory side tolerates abandonment.
//  Lookup (IDLE, combinational): way w hits iff valid && tag match; at most one way hits.
//  read_en && write_en together: treated as a write; the read is ignored.
//  FSM: IDLE, FETCH, RESPOND, WRITE.
//  IDLE read hit: hit=1, read_data = hit way data in the same cycle, stall=0;
//    LRU update at the clock edge; stays in IDLE.
//  IDLE read miss: miss=1, stall=1; latch addr; -> FETCH.
//  FETCH: mem_req=1, mem_we=0, mem_addr = latched addr with [1:0]=0; stall=1.
//    On mem_ack: write victim way (valid=1, tag, mem_rdata); LRU update;
//    latch mem_rdata; -> RESPOND.
//  RESPOND: read_data = latched data, stall=0, hit=miss=0; -> IDLE.
//  IDLE write: hit or miss pulse, stall=1; latch addr/data/hit way; -> WRITE.
//  WRITE: mem_req=1, mem_we=1, mem_wdata = latched data; stall=1.
//    On mem_ack: if hit, update line data and LRU; on miss, no allocation; -> IDLE.
//    stall drops in the IDLE cycle after ack.
//  Handshake: mem_req/mem_we/mem_addr/mem_wdata are registered and held stable
//    until the cycle mem_ack=1 is sampled.
//    mem_req deasserts the cycle after ack; no back-to-back request without passing IDLE.
//  LRU: on access to way w with age a, age[w]=0 and each age<a is incremented;
//    ages stay a permutation of 0..WAYS-1.
//  Victim: lowest-index invalid way, else the way with age == WAYS-1.
//  invalidate in IDLE clears all valid bits at the edge and takes priority over a
//    same-cycle request (request is not accepted; hit=miss=0, stall=1 for that cycle).
//  invalidate outside IDLE is ignored.
//  WAYS=1 degenerates to direct-mapped; age logic is constant.
// TESTING (SETS=8, WAYS=2, mem_ack 3 cycles after mem_req)
//  Cold read 0x40 -> miss pulse, mem_req with mem_addr=0x40; ack with 0xDEADBEEF
//    -> RESPOND read_data=0xDEADBEEF; re-read 0x40 -> hit same cycle, no mem_req.
//  LRU on index 0: read 0x40, then 0x60, then 0x40 (hit), then 0x80 (miss, evicts 0x60)
//    -> 0x40 hit, 0x60 miss.
//  Write hit 0x40 data 0x12345678 -> hit pulse, mem_we=1, stall until ack;
//    read 0x40 -> hit, 0x12345678.
//  Write miss 0x100 -> miss pulse, memory write only; read 0x100 -> miss + FETCH.
//  read_en=write_en=1 at 0x40 -> single memory write, no FETCH.
//  rst_n low during FETCH -> mem_req=0 and stall=0 asynchronously; after release,
//    prior hit address misses.
//  invalidate in IDLE -> read 0x40 misses.

Source files
------------

// File: rtl/sa_wt_cache.sv
// rtl/sa_wt_cache.sv - N-way set-associative write-through no-write-allocate data cache
module sa_wt_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 8,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  invalidate,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  hit,
  output logic                  miss,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int AGE_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WAY_W   = AGE_W;
  localparam int TAG_W   = ADDR_WIDTH - 2 - INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RESPOND, S_WRITE} state_t;

  state_t state_q, state_d;

  // Line storage; only valid and age carry reset values
  logic                  valid_q [SETS][WAYS];
  logic [AGE_W-1:0]      age_q   [SETS][WAYS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];

  // Latched request (word address), write hit way and fetched word
  logic [ADDR_WIDTH-3:0] lat_word;
  logic                  lat_hit;
  logic [WAY_W-1:0]      lat_way;
  logic [DATA_WIDTH-1:0] resp_q;

  logic [INDEX_W-1:0] req_idx, lat_idx;
  logic [TAG_W-1:0]   req_tag, lat_tag;
  logic               hit_any;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim;

  logic               acc_read_miss, acc_write, do_inv;
  logic               fill_en, wr_upd, touch_en;
  logic [INDEX_W-1:0] touch_set;
  logic [WAY_W-1:0]   touch_way;

  logic unused_bits;
  assign unused_bits = ^addr[1:0];

  assign req_idx = addr[INDEX_W+1:2];
  assign req_tag = addr[ADDR_WIDTH-1:INDEX_W+2];
  assign lat_idx = lat_word[INDEX_W-1:0];
  assign lat_tag = lat_word[ADDR_WIDTH-3:INDEX_W];

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: oldest way unless an invalid way exists (lowest index wins)
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[lat_idx][w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[lat_idx][w]) victim = WAY_W'(w);
    end
  end

  // Next state, core-side outputs and array update strobes
  always_comb begin
    state_d       = state_q;
    hit           = 1'b0;
    miss          = 1'b0;
    stall         = 1'b0;
    read_data     = '0;
    acc_read_miss = 1'b0;
    acc_write     = 1'b0;
    do_inv        = 1'b0;
    fill_en       = 1'b0;
    wr_upd        = 1'b0;
    touch_en      = 1'b0;
    touch_set     = req_idx;
    touch_way     = hit_way;
    case (state_q)
      S_IDLE: begin
        // Outputs are held at zero while reset is asserted
        if (rst_n) begin
          if (invalidate) begin
            do_inv = 1'b1;
            stall  = 1'b1;
          end else if (write_en) begin
            hit       = hit_any;
            miss      = !hit_any;
            stall     = 1'b1;
            acc_write = 1'b1;
            state_d   = S_WRITE;
          end else if (read_en) begin
            if (hit_any) begin
              hit       = 1'b1;
              read_data = data_q[req_idx][hit_way];
              touch_en  = 1'b1;
            end else begin
              miss          = 1'b1;
              stall         = 1'b1;
              acc_read_miss = 1'b1;
              state_d       = S_FETCH;
            end
          end
        end
      end
      S_FETCH: begin
        stall = 1'b1;
        if (mem_ack) begin
          fill_en   = 1'b1;
          touch_en  = 1'b1;
          touch_set = lat_idx;
          touch_way = victim;
          state_d   = S_RESPOND;
        end
      end
      S_RESPOND: begin
        read_data = resp_q;
        state_d   = S_IDLE;
      end
      S_WRITE: begin
        stall = 1'b1;
        if (mem_ack) begin
          if (lat_hit) begin
            wr_upd    = 1'b1;
            touch_en  = 1'b1;
            touch_set = lat_idx;
            touch_way = lat_way;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, request latch and registered memory interface
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_word  <= '0;
      lat_hit   <= 1'b0;
      lat_way   <= '0;
      resp_q    <= '0;
    end else begin
      state_q <= state_d;
      if (acc_read_miss || acc_write) begin
        mem_req  <= 1'b1;
        mem_we   <= acc_write;
        mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
        lat_word <= addr[ADDR_WIDTH-1:2];
        lat_hit  <= hit_any;
        lat_way  <= hit_way;
      end
      if (acc_write) mem_wdata <= write_data;
      if ((state_q == S_FETCH || state_q == S_WRITE) && mem_ack) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (fill_en) resp_q <= mem_rdata;
    end
  end

  // Valid bits and LRU ages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
      end
    end else begin
      if (do_inv) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
        end
      end
      if (fill_en) valid_q[lat_idx][victim] <= 1'b1;
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way)
            age_q[touch_set][w] <= '0;
          else if (age_q[touch_set][w] < age_q[touch_set][touch_way])
            age_q[touch_set][w] <= age_q[touch_set][w] + AGE_W'(1);
        end
      end
    end
  end

  // Tag and data arrays: line fill and write-hit update
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[lat_idx][victim]  <= lat_tag;
      data_q[lat_idx][victim] <= mem_rdata;
    end
    if (wr_upd) data_q[lat_idx][lat_way] <= mem_wdata;
  end

endmodule

// File: tb/tb_sa_wt_cache.sv
// tb/tb_sa_wt_cache.sv - randomized self-checking bench for sa_wt_cache
module tb_sa_wt_cache;

  localparam int SETS = 8;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_en = 1'b0, write_en = 1'b0, invalidate = 1'b0;
  logic [31:0] addr = '0, write_data = '0;
  logic [31:0] read_data;
  logic        hit, miss, stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  sa_wt_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .write_en(write_en),
    .addr(addr), .write_data(write_data), .invalidate(invalidate),
    .read_data(read_data), .hit(hit), .miss(miss), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backing memory seen by the bus responder, and the bench's own view of it
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Completed bus transactions
  logic        txn_we [$];
  logic [31:0] txn_addr [$];
  logic [31:0] txn_data [$];

  // Memory responder: ack 3 cycles after request, check request stability
  initial begin
    int cnt;
    logic [64:0] cap;
    cnt = 0;
    cap = '0;
    forever begin
      @(negedge clk);
      if (!mem_req || mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else begin
        if (cnt == 0) cap = {mem_we, mem_addr, mem_wdata};
        else check("mem_hold", {31'b0, mem_we, mem_addr, mem_wdata}, {31'b0, cap});
        cnt++;
        if (cnt == 3) begin
          txn_we.push_back(mem_we);
          txn_addr.push_back(mem_addr);
          txn_data.push_back(mem_wdata);
          if (mem_we) bus_mem[mem_addr] = mem_wdata;
          else mem_rdata = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : init_word(mem_addr);
          mem_ack = 1'b1;
        end
      end
    end
  end

  // Reference cache: per set a list of resident word addresses, most recent first
  logic [31:0] mdl_set [SETS][$];

  function automatic int set_of(input logic [31:0] a);
    return int'(a[4:2]);
  endfunction

  function automatic bit mdl_has(input logic [31:0] a);
    foreach (mdl_set[set_of(a)][i]) if (mdl_set[set_of(a)][i] == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mdl_touch(input logic [31:0] a);
    int s;
    s = set_of(a);
    for (int i = mdl_set[s].size() - 1; i >= 0; i--)
      if (mdl_set[s][i] == a) mdl_set[s].delete(i);
    mdl_set[s].push_front(a);
    if (mdl_set[s].size() > WAYS) void'(mdl_set[s].pop_back());
  endtask

  task automatic mdl_clear();
    for (int s = 0; s < SETS; s++) mdl_set[s].delete();
  endtask

  task automatic clear_txn();
    txn_we.delete();
    txn_addr.delete();
    txn_data.delete();
  endtask

  task automatic wait_stall_low(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 50);
    check(tag, {95'b0, stall}, 96'd0);
  endtask

  // Every op starts 1ns after a rising edge and ends 1ns after a rising edge
  task automatic do_read(input logic [31:0] a);
    logic [31:0] wa, exp_d;
    bit exp_hit;
    wa = {a[31:2], 2'b00};
    exp_hit = mdl_has(wa);
    exp_d = ref_read(wa);
    clear_txn();
    addr = a;
    read_en = 1'b1;
    @(negedge clk);
    check("rd_hit", {95'b0, hit}, {95'b0, exp_hit});
    check("rd_miss", {95'b0, miss}, {95'b0, !exp_hit});
    if (exp_hit) begin
      check("rd_hit_stall", {95'b0, stall}, 96'd0);
      check("rd_hit_data", {64'b0, read_data}, {64'b0, exp_d});
      @(posedge clk); #1;
      read_en = 1'b0;
      check("rd_hit_noreq", {95'b0, mem_req}, 96'd0);
    end else begin
      check("rd_miss_stall", {95'b0, stall}, 96'd1);
      @(posedge clk); #1;
      read_en = 1'b0;
      check("fetch_req", {94'b0, mem_req, mem_we}, 96'd2);
      wait_stall_low("fetch_timeout");
      check("respond_data", {64'b0, read_data}, {64'b0, exp_d});
      check("respond_flags", {94'b0, hit, miss}, 96'd0);
      @(posedge clk); #1;
      check("fetch_txn_cnt", 96'(txn_we.size()), 96'd1);
      if (txn_we.size() == 1)
        check("fetch_txn", {63'b0, txn_we[0], txn_addr[0]}, {64'b0, wa});
    end
    mdl_touch(wa);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both);
    logic [31:0] wa;
    bit exp_hit;
    wa = {a[31:2], 2'b00};
    exp_hit = mdl_has(wa);
    clear_txn();
    addr = a;
    write_data = d;
    write_en = 1'b1;
    read_en = both;
    @(negedge clk);
    check("wr_hit", {95'b0, hit}, {95'b0, exp_hit});
    check("wr_miss", {95'b0, miss}, {95'b0, !exp_hit});
    check("wr_stall", {95'b0, stall}, 96'd1);
    @(posedge clk); #1;
    write_en = 1'b0;
    read_en = 1'b0;
    wait_stall_low("write_timeout");
    @(posedge clk); #1;
    check("write_txn_cnt", 96'(txn_we.size()), 96'd1);
    if (txn_we.size() == 1)
      check("write_txn", {31'b0, txn_we[0], txn_addr[0], txn_data[0]}, {31'b0, 1'b1, wa, d});
    ref_mem[wa] = d;
    if (exp_hit) mdl_touch(wa);
  endtask

  task automatic do_inv(input logic [31:0] a);
    addr = a;
    invalidate = 1'b1;
    read_en = 1'b1;
    @(negedge clk);
    check("inv_flags", {93'b0, hit, miss, stall}, 96'd1);
    @(posedge clk); #1;
    invalidate = 1'b0;
    read_en = 1'b0;
    check("inv_noreq", {95'b0, mem_req}, 96'd0);
    mdl_clear();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    mdl_clear();
    bus_mem[32'h40] = 32'hDEADBEEF;
    ref_mem[32'h40] = 32'hDEADBEEF;

    // Reset state
    #23;
    check("reset_out", {29'b0, mem_req, mem_we, hit, miss, stall, read_data, mem_addr},
          96'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss then hit
    do_read(32'h40);
    do_read(32'h40);

    // LRU on set 0
    do_read(32'h60);
    do_read(32'h40);
    do_read(32'h80);
    do_read(32'h40);
    do_read(32'h60);

    // Write hit, write miss, read+write together
    do_write(32'h40, 32'h12345678, 1'b0);
    do_read(32'h40);
    do_write(32'h100, 32'hCAFEF00D, 1'b0);
    do_read(32'h100);
    do_write(32'h40, 32'hA1B2C3D4, 1'b1);
    do_read(32'h43);

    // Reset asserted while a fetch is outstanding
    clear_txn();
    addr = 32'h200;
    read_en = 1'b1;
    @(negedge clk);
    check("rst_pre_miss", {95'b0, miss}, 96'd1);
    @(posedge clk); #1;
    check("rst_pre_req", {95'b0, mem_req}, 96'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_async", {93'b0, mem_req, stall, miss}, 96'd0);
    read_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mdl_clear();
    do_read(32'h40);

    // Invalidate beats a same-cycle read
    do_read(32'h40);
    do_inv(32'h40);
    do_read(32'h40);

    // Randomized traffic over a small address pool
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      if (r < 50) do_read(a);
      else if (r < 85) do_write(a, $urandom, 1'b0);
      else if (r < 93) do_write(a, $urandom, 1'b1);
      else do_inv(a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
